// File: rtl/multicycle_controller.sv
// Sequencing FSM for a 32-bit multicycle MIPS datapath with a shared memory port.
// Decodes op/funct into datapath selects/enables, stalls on mem_ready and counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       alucontrol,
  output logic             regwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             illegal_op,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instret
);

  // state    | meaning
  // FETCH    | read instr at PC, PC <= PC+4
  // DECODE   | decode op/funct, ALUOut <= branch target
  // MEMADR   | ALUOut <= rs + signimm
  // MEMRD    | read data memory at ALUOut
  // MEMWB    | rt <= memory data
  // MEMWR    | write rt to memory at ALUOut
  // EXECUTE  | R-type ALU operation
  // ALUWB    | rd <= ALUOut
  // BRANCH   | beq compare, PC <= ALUOut if equal
  // ADDIEXEC | ALUOut <= rs + signimm
  // ADDIWB   | rt <= ALUOut
  // JUMP     | PC <= jump target
  // JAL      | PC <= jump target, $31 <= PC+4
  // JR       | PC <= rs
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 4'b0010;
    regwrite   = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            case (funct)
              6'b001000: state_d = S_JR;
              6'b100000, 6'b100010, 6'b100100,
              6'b100101, 6'b101010: state_d = S_EXECUTE;
              default: begin
                state_d    = S_FETCH;
                illegal_op = 1'b1;
              end
            endcase
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEXEC;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ready;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = 4'b0110;
          6'b100100: alucontrol = 4'b0000;
          6'b100101: alucontrol = 4'b0001;
          6'b101010: alucontrol = 4'b0111;
          default:   alucontrol = 4'b0010;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 4'b0110;
        pcsrc      = 2'b01;
        pcen       = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so the link value is valid this cycle
        pcsrc    = 2'b10;
        pcen     = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pcsrc   = 2'b11;
        pcen    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state_out = state_q;
  assign instret   = instret_q;

endmodule
